// File: rtl/fx_arb_if.sv
// rtl/fx_arb_if.sv - fx register bus bundle: two master request ports plus slave strobe/data side
interface fx_arb_if;
  logic        m0_req;
  logic        m0_wr;
  logic [21:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic [7:0]  m0_rdata;
  logic        m1_req;
  logic        m1_wr;
  logic [21:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  m1_rdata;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        arb_busy;

  // Arbiter view
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  fx_q,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, arb_busy
  );

  // Environment view: masters and slave fan-out
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output fx_q,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, arb_busy
  );
endinterface

// File: rtl/fx_arb.sv
// rtl/fx_arb.sv - two-master fx bus arbiter/sequencer; FX_ARB_RR_EN selects round-robin over fixed priority
module fx_arb #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic   clk_sys,
  input  logic   rst_n,
  fx_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        win_q, win_d;
  logic        wr_q, wr_d;
  logic [21:0] waddr_q, waddr_d;
  logic [21:0] raddr_q, raddr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        gnt_id;

`ifdef FX_ARB_RR_EN
  logic        last_q, last_d;

  // On contention the master not granted last wins; a lone requester always wins.
  always_comb begin
    gnt_id = 1'b0;
    if (bus.m0_req && bus.m1_req) gnt_id = ~last_q;
    else                          gnt_id = bus.m1_req;
  end
`else
  always_comb begin
    gnt_id = ~bus.m0_req;
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef FX_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          win_d   = gnt_id;
          wr_d    = gnt_id ? bus.m1_wr : bus.m0_wr;
          state_d = ISSUE;
`ifdef FX_ARB_RR_EN
          last_d  = gnt_id;
`endif
          // Address/data registers only move when their own direction is used.
          if (gnt_id ? bus.m1_wr : bus.m0_wr) begin
            waddr_d = gnt_id ? bus.m1_addr : bus.m0_addr;
            data_d  = gnt_id ? bus.m1_wdata : bus.m0_wdata;
          end else begin
            raddr_d = gnt_id ? bus.m1_addr : bus.m0_addr;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (win_q) rdata1_d = bus.fx_q;
          else       rdata0_d = bus.fx_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef FX_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef FX_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.fx_wr    = (state_q == ISSUE) && wr_q;
  assign bus.fx_rd    = (state_q == ISSUE) && !wr_q;
  assign bus.fx_waddr = waddr_q;
  assign bus.fx_raddr = raddr_q;
  assign bus.fx_data  = data_q;
  assign bus.m0_ack   = (state_q == ACK) && !win_q;
  assign bus.m1_ack   = (state_q == ACK) && win_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.arb_busy = (state_q != IDLE);

endmodule
